sdram_pip_reader: RTL and testbench



---
 rtl/sdram_pip_reader_if.sv | 30 +++
 rtl/sdram_pip_reader.sv | 143 ++++++++++++++
 tb/tb_sdram_pip_reader.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_pip_reader_if.sv
// Pixel-side bundle between the PIP reader, its two SDRAM read FIFOs and the VGA stage.
// Handshake: iREQ is a one-cycle pixel request with no back-pressure; every request not
// cancelled by a coincident iFRAME_START yields exactly one oVALID cycle two clocks later.
interface sdram_pip_reader_if #(
  parameter int DW = 16
);
  logic          iFRAME_START;
  logic          iREQ;
  logic [DW-1:0] RD1_DATA;
  logic          RD1_EMPTY;
  logic [8:0]    RD1_USE;
  logic [DW-1:0] RD2_DATA;
  logic          RD2_EMPTY;
  logic          RD1;
  logic          RD2;
  logic          RD_LOAD;
  logic [DW-1:0] oDATA;
  logic          oVALID;
  logic          oUNDERRUN;

  modport master (
    input  iFRAME_START, iREQ, RD1_DATA, RD1_EMPTY, RD1_USE, RD2_DATA, RD2_EMPTY,
    output RD1, RD2, RD_LOAD, oDATA, oVALID, oUNDERRUN
  );

  modport slave (
    output iFRAME_START, iREQ, RD1_DATA, RD1_EMPTY, RD1_USE, RD2_DATA, RD2_EMPTY,
    input  RD1, RD2, RD_LOAD, oDATA, oVALID, oUNDERRUN
  );
endinterface

// File: rtl/sdram_pip_reader.sv
// Pops main and inset read FIFOs in raster order and muxes the inset over the main image.
// Optional macro PIP_BORDER_EN: paint the inset's outer edge pixels white.
module sdram_pip_reader #(
  parameter int            DW        = 16,
  parameter int            H_ACT     = 640,
  parameter int            V_ACT     = 480,
  parameter int            PIP_X     = 304,
  parameter int            PIP_Y     = 16,
  parameter int            PIP_W     = 320,
  parameter int            PIP_H     = 240,
  parameter int            LOAD_CYC  = 4,
  parameter int            FILL_LVL  = 64,
  parameter logic [DW-1:0] BLANK_PIX = 16'h0000
) (
  input  logic                CLK,
  input  logic                RESET_N,
  sdram_pip_reader_if.master  bus,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {IDLE, LOAD, FILL, ACTIVE, DONE} state_t;

  localparam logic [10:0] X0   = 11'(PIP_X);
  localparam logic [10:0] X1   = 11'(PIP_X + PIP_W);
  localparam logic [10:0] Y0   = 11'(PIP_Y);
  localparam logic [10:0] Y1   = 11'(PIP_Y + PIP_H);
  localparam logic [10:0] XL   = 11'(H_ACT - 1);
  localparam logic [10:0] YL   = 11'(V_ACT - 1);
  localparam logic [7:0]  LC   = 8'(LOAD_CYC - 1);
  localparam logic [8:0]  FL   = 9'(FILL_LVL);

  state_t        state;
  logic [10:0]   x, y;
  logic [7:0]    load_cnt;
  logic          s1_req, s1_blank, s1_under, s1_win;
  logic          rd_load_r, valid_r, underrun_r;
  logic [DW-1:0] data_r, pix_sel;
  logic          restart, accept, inwin, under;

  always_comb begin
    restart = bus.iFRAME_START && (state != LOAD);
    accept  = bus.iREQ && (state == ACTIVE) && !restart;
    inwin   = (x >= X0) && (x < X1) && (y >= Y0) && (y < Y1);
    under   = accept && (bus.RD1_EMPTY || (inwin && bus.RD2_EMPTY));
  end

  // Main FIFO pops on every active pixel, covered or not, so the main stream stays aligned.
  assign bus.RD1 = accept && !bus.RD1_EMPTY;
  assign bus.RD2 = accept && inwin && !bus.RD2_EMPTY;

`ifdef PIP_BORDER_EN
  logic s1_border, border;
  assign border = inwin && ((x == X0) || (x == X1 - 11'd1) || (y == Y0) || (y == Y1 - 11'd1));
`endif

  always_comb begin
    pix_sel = bus.RD1_DATA;
    if (s1_blank) pix_sel = BLANK_PIX;
    else if (s1_win) begin
`ifdef PIP_BORDER_EN
      pix_sel = s1_border ? {DW{1'b1}} : bus.RD2_DATA;
`else
      pix_sel = bus.RD2_DATA;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      load_cnt   <= '0;
      s1_req     <= 1'b0;
      s1_blank   <= 1'b1;
      s1_under   <= 1'b0;
      s1_win     <= 1'b0;
`ifdef PIP_BORDER_EN
      s1_border  <= 1'b0;
`endif
      rd_load_r  <= 1'b0;
      valid_r    <= 1'b0;
      underrun_r <= 1'b0;
      data_r     <= BLANK_PIX;
    end else begin
      // Stage 1: decisions taken at request time, aligned with the FIFO q one clock later.
      s1_req   <= bus.iREQ && !restart;
      s1_blank <= !accept || under;
      s1_under <= under;
      s1_win   <= inwin;
`ifdef PIP_BORDER_EN
      s1_border <= border;
`endif
      valid_r <= s1_req;
      data_r  <= pix_sel;
      if (restart) underrun_r <= 1'b0;
      else if (s1_req && s1_under) underrun_r <= 1'b1;

      if (restart) begin
        state     <= LOAD;
        x         <= '0;
        y         <= '0;
        load_cnt  <= '0;
        rd_load_r <= 1'b1;
      end else begin
        case (state)
          LOAD: begin
            if (load_cnt == LC) begin
              state     <= FILL;
              rd_load_r <= 1'b0;
            end else begin
              load_cnt <= load_cnt + 8'd1;
            end
          end
          FILL: if (bus.RD1_USE >= FL) state <= ACTIVE;
          ACTIVE: begin
            if (accept) begin
              if (x == XL) begin
                x <= '0;
                if (y == YL) begin
                  y     <= '0;
                  state <= DONE;
                end else begin
                  y <= y + 11'd1;
                end
              end else begin
                x <= x + 11'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.RD_LOAD   = rd_load_r;
  assign bus.oVALID    = valid_r;
  assign bus.oDATA     = data_r;
  assign bus.oUNDERRUN = underrun_r;
  assign dbg_state     = state;

endmodule

// File: tb/tb_sdram_pip_reader.sv
// Self-checking bench for sdram_pip_reader on a scaled 40x30 raster with a 20x15 inset.
// Build with +define+PIP_BORDER_EN to exercise the border variant.
module tb_sdram_pip_reader;
  localparam int DW = 16, H = 40, V = 30, PX = 19, PY = 1, PW = 20, PH = 15;
  localparam int LOADC = 4, FILL = 64;
  localparam logic [DW-1:0] BLANK = 16'h0000;
  localparam int EW = 32 + 11 + 11 + DW;
  localparam logic [10:0] NOPOS = 11'h7FF;

  logic       CLK, RESET_N;
  logic [2:0] dbg_state;
  int         checks = 0, errors = 0, cyc = 0;

  sdram_pip_reader_if #(.DW(DW)) bus();

  sdram_pip_reader #(
    .DW(DW), .H_ACT(H), .V_ACT(V), .PIP_X(PX), .PIP_Y(PY), .PIP_W(PW), .PIP_H(PH),
    .LOAD_CYC(LOADC), .FILL_LVL(FILL), .BLANK_PIX(BLANK)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .bus(bus), .dbg_state(dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // FIFO models: ramp on port 1, 0x8000+k on port 2, pointers reloaded by RD_LOAD
  int ptr1 = 0, ptr2 = 0, pop1 = 0, pop2 = 0;
  always @(posedge CLK) begin
    if (bus.RD_LOAD) begin
      ptr1 <= 0; ptr2 <= 0; pop1 <= 0; pop2 <= 0;
    end else begin
      if (bus.RD1) begin
        bus.RD1_DATA <= DW'(ptr1);
        ptr1 <= ptr1 + 1;
        pop1 <= pop1 + 1;
      end
      if (bus.RD2) begin
        bus.RD2_DATA <= 16'h8000 + DW'(ptr2);
        ptr2 <= ptr2 + 1;
        pop2 <= pop2 + 1;
      end
    end
  end

  // reference model state
  int mx, my, k1, k2;
  bit m_active;
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] pix [V][H];

  function automatic bit in_win(int x, int y);
    return (x >= PX) && (x < PX + PW) && (y >= PY) && (y < PY + PH);
  endfunction

  function automatic bit on_edge(int x, int y);
    return in_win(x, y) && (x == PX || x == PX + PW - 1 || y == PY || y == PY + PH - 1);
  endfunction

  // driver tasks (entered and left on a negedge)
  task automatic drive_req();
    logic [DW-1:0] e;
    logic [10:0]   ex, ey;
    bit            w;
    bus.iREQ = 1'b1;
    ex = NOPOS; ey = NOPOS; e = BLANK;
    if (m_active) begin
      ex = 11'(mx); ey = 11'(my);
      w = in_win(mx, my);
      if (bus.RD1_EMPTY || (w && bus.RD2_EMPTY)) e = BLANK;
      else if (w) e = 16'h8000 + DW'(k2);
      else e = DW'(k1);
`ifdef PIP_BORDER_EN
      if (!bus.RD1_EMPTY && !bus.RD2_EMPTY && on_edge(mx, my)) e = 16'hFFFF;
`endif
      if (!bus.RD1_EMPTY) k1++;
      if (w && !bus.RD2_EMPTY) k2++;
      if (mx == H - 1) begin
        mx = 0;
        if (my == V - 1) begin my = 0; m_active = 0; end
        else my++;
      end else mx++;
    end
    exp_q.push_back({32'(cyc), ex, ey, e});
    @(negedge CLK);
    bus.iREQ = 1'b0;
  endtask

  task automatic start_frame(input bit with_req, input bit fill_wait);
    int n;
    bus.RD1_USE = 9'd0;
    bus.iFRAME_START = 1'b1;
    bus.iREQ = with_req;
    #1;
    if (with_req) check_eq("abort_no_pop", 32'(bus.RD1), 0);
    mx = 0; my = 0; k1 = 0; k2 = 0; m_active = 0;
    @(negedge CLK);
    bus.iFRAME_START = 1'b0;
    bus.iREQ = 1'b0;
    n = 0;
    repeat (10) begin
      if (bus.RD_LOAD) n++;
      @(negedge CLK);
    end
    check_eq("load_cycles", 32'(n), 32'(LOADC));
    check_eq("state_fill", 32'(dbg_state), 2);
    check_eq("underrun_clear", 32'(bus.oUNDERRUN), 0);
    if (fill_wait) begin
      bus.RD1_USE = 9'(FILL - 1);
      repeat (3) @(negedge CLK);
      check_eq("fill_hold", 32'(dbg_state), 2);
      drive_req();
    end
    bus.RD1_USE = 9'(FILL);
    @(negedge CLK);
    check_eq("state_active", 32'(dbg_state), 3);
    m_active = 1;
  endtask

  task automatic run_frame(input int n, input bit gaps, input bit faults);
    for (int i = 0; i < n; i++) begin
      if (faults) begin
        bus.RD1_EMPTY = (my == 2 && mx >= 5 && mx < 8);
        bus.RD2_EMPTY = (my == 3 && mx == 25);
      end
      if (m_active && mx == H - 1 && my == V - 1) check_eq("state_before_last", 32'(dbg_state), 3);
      drive_req();
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
    bus.RD1_EMPTY = 1'b0;
    bus.RD2_EMPTY = 1'b0;
  endtask

  task automatic drain();
    repeat (5) @(negedge CLK);
    check_eq("drain", 32'(exp_q.size()), 0);
  endtask

  task automatic check_frame_pix();
`ifdef PIP_BORDER_EN
    check_eq("pip_top_left", 32'(pix[PY][PX]), 32'h0000FFFF);
    check_eq("pip_bot_right", 32'(pix[PY+PH-1][PX+PW-1]), 32'h0000FFFF);
    check_eq("pip_right_edge", 32'(pix[12][PX+PW-1]), 32'h0000FFFF);
    check_eq("pip_inner", 32'(pix[PY+1][PX+1]), 32'h8000 + PW + 1);
`else
    check_eq("pip_top_left", 32'(pix[PY][PX]), 32'h8000);
    check_eq("pip_bot_right", 32'(pix[PY+PH-1][PX+PW-1]), 32'h8000 + PW * PH - 1);
`endif
    check_eq("main_left", 32'(pix[PY][PX-1]), 32'(PY * H + PX - 1));
    check_eq("main_right", 32'(pix[PY+PH-1][PX+PW]), 32'((PY + PH - 1) * H + PX + PW));
    check_eq("pop1", 32'(pop1), 32'(H * V));
    check_eq("pop2", 32'(pop2), 32'(PW * PH));
    check_eq("state_done", 32'(dbg_state), 4);
  endtask

  // scoreboard: pop expected pixel on every oVALID
  logic [EW-1:0] mon_ent;
  always @(negedge CLK) begin
    if (RESET_N && bus.oVALID) begin
      if (exp_q.size() == 0) check_eq("spurious_valid", 32'(bus.oVALID), 0);
      else begin
        mon_ent = exp_q.pop_front();
        check_eq("pixel", 32'(bus.oDATA), 32'(mon_ent[DW-1:0]));
        check_eq("latency", 32'(cyc) - mon_ent[EW-1 -: 32], 2);
        if (mon_ent[DW+21 -: 11] != NOPOS)
          pix[int'(mon_ent[DW+10 -: 11])][int'(mon_ent[DW+21 -: 11])] = bus.oDATA;
      end
    end
  end

  initial begin
    bus.iFRAME_START = 1'b0;
    bus.iREQ = 1'b0;
    bus.RD1_EMPTY = 1'b0;
    bus.RD2_EMPTY = 1'b0;
    bus.RD1_USE = 9'd0;
    m_active = 0; mx = 0; my = 0; k1 = 0; k2 = 0;
    RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    check_eq("rst_rd1", 32'(bus.RD1), 0);
    check_eq("rst_rd2", 32'(bus.RD2), 0);
    check_eq("rst_rd_load", 32'(bus.RD_LOAD), 0);
    check_eq("rst_data", 32'(bus.oDATA), 32'(BLANK));
    check_eq("rst_valid", 32'(bus.oVALID), 0);
    check_eq("rst_underrun", 32'(bus.oUNDERRUN), 0);
    check_eq("rst_state", 32'(dbg_state), 0);
    RESET_N = 1'b1;
    @(negedge CLK);
    drive_req();

    // frame 1: clean frame with random request gaps
    start_frame(0, 1);
    run_frame(H * V, 1, 0);
    drain();
    check_frame_pix();
    drive_req();
    drain();

    // frame 2: main FIFO empty for 3 requests, inset FIFO empty for 1
    start_frame(0, 0);
    run_frame(H * V, 0, 1);
    drain();
    check_eq("underrun_set", 32'(bus.oUNDERRUN), 1);
    check_eq("underrun_pix", 32'(pix[2][6]), 32'(BLANK));
    check_eq("state_done_f2", 32'(dbg_state), 4);

    // frame 3 aborted at (10,5) by a frame start coincident with a request
    start_frame(0, 0);
    run_frame(5 * H + 10, 0, 0);
    start_frame(1, 0);
    run_frame(H * V, 0, 0);
    drain();
    check_frame_pix();

    // reset in the middle of a frame
    start_frame(0, 0);
    run_frame(100, 0, 0);
    bus.iREQ = 1'b1;
    RESET_N = 1'b0;
    #1;
    check_eq("mid_rst_rd1", 32'(bus.RD1), 0);
    check_eq("mid_rst_valid", 32'(bus.oVALID), 0);
    check_eq("mid_rst_data", 32'(bus.oDATA), 32'(BLANK));
    check_eq("mid_rst_state", 32'(dbg_state), 0);
    exp_q.delete();
    m_active = 0;
    bus.iREQ = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    drive_req();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
